// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 16x2 refresh controller.
package lcd_pkg;

  // Top-level sequencer states
  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    ADDR,
    FETCH,
    DATA,
    WAIT_REQ
  } state_e;

  // Phases of one LCD bus write
  typedef enum logic [1:0] {
    SETUP,
    E_HI,
    SETTLE
  } wr_state_e;

  localparam logic [7:0] CMD_FUNC  = 8'h38;  // 8-bit bus, 2 lines
  localparam logic [7:0] CMD_DISP  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_ENTRY = 8'h06;  // auto-increment
  localparam logic [7:0] CMD_CLR   = 8'h01;  // clear, needs the long settle
  localparam logic [7:0] DDRAM_L1  = 8'h80;
  localparam logic [7:0] DDRAM_L2  = 8'hC0;

  localparam int unsigned LINE_LEN = 16;
  localparam int unsigned NUM_POS  = 32;

  // Init command for step 0..3
  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    case (step)
      2'd0:    return CMD_FUNC;
      2'd1:    return CMD_DISP;
      2'd2:    return CMD_ENTRY;
      default: return CMD_CLR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_write_cycle.sv
// One timed LCD bus write: SETUP (1 cycle), E_HI (E_CYCLES), SETTLE (CMD_WAIT or CLR_WAIT).
// o_done is high during the last SETTLE cycle so the caller can advance on the next edge.
module lcd_write_cycle
  import lcd_pkg::*;
#(
  parameter int unsigned E_CYCLES = 12,
  parameter int unsigned CMD_WAIT = 2500,
  parameter int unsigned CLR_WAIT = 82000,
  parameter int unsigned CNT_W    = 20
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_rs_in,
  input  logic [7:0] i_data_in,
  input  logic       i_long_wait,
  output logic       o_lcd_rs,
  output logic       o_lcd_e,
  output logic [7:0] o_lcd_data,
  output logic       o_done
);

  wr_state_e        r_sub;
  logic             r_busy;
  logic             r_long;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_wait_last;

  assign w_wait_last = r_long ? CNT_W'(CLR_WAIT - 1) : CNT_W'(CMD_WAIT - 1);
  assign o_done      = r_busy && (r_sub == SETTLE) && (r_cnt == w_wait_last);

  // Write phase sequencing; rs/data are latched once at start and held until the next start
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sub      <= SETUP;
      r_busy     <= 1'b0;
      r_long     <= 1'b0;
      r_cnt      <= '0;
      o_lcd_rs   <= 1'b0;
      o_lcd_e    <= 1'b0;
      o_lcd_data <= '0;
    end else if (!r_busy) begin
      if (i_start) begin
        r_busy     <= 1'b1;
        r_sub      <= SETUP;
        r_long     <= i_long_wait;
        r_cnt      <= '0;
        o_lcd_rs   <= i_rs_in;
        o_lcd_data <= i_data_in;
      end
    end else begin
      case (r_sub)
        SETUP: begin
          r_sub   <= E_HI;
          o_lcd_e <= 1'b1;
          r_cnt   <= '0;
        end
        E_HI: begin
          if (r_cnt == CNT_W'(E_CYCLES - 1)) begin
            o_lcd_e <= 1'b0;
            r_sub   <= SETTLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (o_done) r_busy <= 1'b0;
          else        r_cnt  <= r_cnt + 1'b1;
        end
        default: r_sub <= SETUP;
      endcase
    end
  end

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// HD44780 16x2 refresh sequencer: power-on wait, init commands, then endless refresh of
// both lines (address command per line, fetch from string generator, data write).
// Optional: define LCD_FRAME_SYNC_EN to add i_frame_req and gate each frame on it.
module lcd_refresh_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned INIT_WAIT = 750000,
  parameter int unsigned E_CYCLES  = 12,
  parameter int unsigned CMD_WAIT  = 2500,
  parameter int unsigned CLR_WAIT  = 82000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_char_in,
`ifdef LCD_FRAME_SYNC_EN
  input  logic       i_frame_req,
`endif
  output logic [4:0] o_index,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_e,
  output logic [7:0] o_lcd_data,
  output logic       o_init_done,
  output logic       o_frame_done
);

  state_e           r_state;
  logic [CNT_W-1:0] r_pwr_cnt;
  logic [1:0]       r_step;
  logic             r_pend;     // write issued, waiting for its done
  logic             r_fetch;    // second FETCH cycle
  logic [7:0]       r_char;
  logic [4:0]       r_index;
  logic             r_init_done;
  logic             r_frame_done;

  logic             w_start;
  logic             w_rs;
  logic             w_long;
  logic             w_done;
  logic [7:0]       w_data;
  state_e           w_after_frame;

`ifdef LCD_FRAME_SYNC_EN
  assign w_after_frame = WAIT_REQ;
`else
  assign w_after_frame = ADDR;
`endif

  // Write request decode; the first init write is issued on the last power-wait cycle
  always_comb begin
    w_start = 1'b0;
    w_rs    = 1'b0;
    w_data  = CMD_FUNC;
    case (r_state)
      PWR_WAIT: w_start = (r_pwr_cnt == CNT_W'(INIT_WAIT - 1));
      INIT: begin
        w_start = !r_pend;
        w_data  = init_cmd(r_step);
      end
      ADDR: begin
        w_start = !r_pend;
        w_data  = r_index[4] ? DDRAM_L2 : DDRAM_L1;
      end
      DATA: begin
        w_start = !r_pend;
        w_rs    = 1'b1;
        w_data  = r_char;
      end
      default: ;
    endcase
    w_long = !w_rs && (w_data == CMD_CLR);
  end

  // Main sequencer with registered index/status outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= PWR_WAIT;
      r_pwr_cnt    <= '0;
      r_step       <= '0;
      r_pend       <= 1'b0;
      r_fetch      <= 1'b0;
      r_char       <= '0;
      r_index      <= '0;
      r_init_done  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_start) r_pend <= 1'b1;
      case (r_state)
        PWR_WAIT: begin
          if (w_start) begin
            r_state <= INIT;
            r_step  <= '0;
          end else begin
            r_pwr_cnt <= r_pwr_cnt + 1'b1;
          end
        end
        INIT: begin
          if (w_done) begin
            r_pend <= 1'b0;
            if (r_step == 2'd3) begin
              r_init_done <= 1'b1;
              r_state     <= w_after_frame;
            end else begin
              r_step <= r_step + 1'b1;
            end
          end
        end
        ADDR: begin
          if (w_done) begin
            r_pend  <= 1'b0;
            r_fetch <= 1'b0;
            r_state <= FETCH;
          end
        end
        FETCH: begin
          // Generator output is valid two edges after the index changes
          if (!r_fetch) begin
            r_fetch <= 1'b1;
          end else begin
            r_char  <= i_char_in;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_done) begin
            r_pend  <= 1'b0;
            r_fetch <= 1'b0;
            if (r_index == 5'(NUM_POS - 1)) begin
              r_frame_done <= 1'b1;
              r_index      <= '0;
              r_state      <= w_after_frame;
            end else begin
              r_index <= r_index + 1'b1;
              r_state <= (r_index == 5'(LINE_LEN - 1)) ? ADDR : FETCH;
            end
          end
        end
        WAIT_REQ: begin
`ifdef LCD_FRAME_SYNC_EN
          if (i_frame_req) r_state <= ADDR;
`else
          r_state <= ADDR;
`endif
        end
        default: r_state <= PWR_WAIT;
      endcase
    end
  end

  lcd_write_cycle #(
    .E_CYCLES(E_CYCLES),
    .CMD_WAIT(CMD_WAIT),
    .CLR_WAIT(CLR_WAIT),
    .CNT_W   (CNT_W)
  ) u_write (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (w_start),
    .i_rs_in    (w_rs),
    .i_data_in  (w_data),
    .i_long_wait(w_long),
    .o_lcd_rs   (o_lcd_rs),
    .o_lcd_e    (o_lcd_e),
    .o_lcd_data (o_lcd_data),
    .o_done     (w_done)
  );

  assign o_index      = r_index;
  assign o_lcd_rw     = 1'b0;
  assign o_init_done  = r_init_done;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Bench for lcd_refresh_ctrl with a clock-display string generator model attached.
`timescale 1ns/1ps
module tb_lcd_refresh_ctrl;

  localparam int unsigned INIT_WAIT = 20;
  localparam int unsigned E_CYCLES  = 2;
  localparam int unsigned CMD_WAIT  = 5;
  localparam int unsigned CLR_WAIT  = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] char_in = 8'h20;
  logic [4:0] index;
  logic       lcd_rs, lcd_rw, lcd_e, init_done, frame_done;
  logic [7:0] lcd_data;
`ifdef LCD_FRAME_SYNC_EN
  logic       frame_req = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int unsigned digit[6] = '{1, 2, 3, 4, 5, 6};

  // Bus monitor results
  logic [8:0] wr_q[$];
  int         hi_q[$];
  int         cyc = 0, last_fall = 0, init_cyc = -1, fd_cnt = 0;
  int         rise_cnt = 0, data_rise = 0, bad_stab = 0;
  logic       m_pe = 1'b0, m_prs = 1'b0;
  logic [7:0] m_pd = 8'h00;
  int         m_ehi = 0;

  always #5 clk = ~clk;

  lcd_refresh_ctrl #(
    .INIT_WAIT(INIT_WAIT),
    .E_CYCLES (E_CYCLES),
    .CMD_WAIT (CMD_WAIT),
    .CLR_WAIT (CLR_WAIT),
    .CNT_W    (20)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_char_in   (char_in),
`ifdef LCD_FRAME_SYNC_EN
    .i_frame_req (frame_req),
`endif
    .o_index     (index),
    .o_lcd_rs    (lcd_rs),
    .o_lcd_rw    (lcd_rw),
    .o_lcd_e     (lcd_e),
    .o_lcd_data  (lcd_data),
    .o_init_done (init_done),
    .o_frame_done(frame_done)
  );

  // Display text "        " / "HH:MM:SS        " model
  function automatic logic [7:0] gen_char(input int pos);
    case (pos)
      16:      return 8'h30 + 8'(digit[0]);
      17:      return 8'h30 + 8'(digit[1]);
      18:      return 8'h3A;
      19:      return 8'h30 + 8'(digit[2]);
      20:      return 8'h30 + 8'(digit[3]);
      21:      return 8'h3A;
      22:      return 8'h30 + 8'(digit[4]);
      23:      return 8'h30 + 8'(digit[5]);
      default: return 8'h20;
    endcase
  endfunction

  // String generator: registered one cycle after index
  always @(posedge clk) char_in <= gen_char(int'(index));

  // Monitor samples 3 ns after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #3;
      cyc++;
      if (lcd_e && !m_pe) begin
        wr_q.push_back({lcd_rs, lcd_data});
        rise_cnt++;
        if (lcd_rs) data_rise++;
        if (lcd_rs !== m_prs || lcd_data !== m_pd) bad_stab++;
        m_ehi = 1;
      end else if (lcd_e) begin
        m_ehi++;
        if (lcd_rs !== m_prs || lcd_data !== m_pd) bad_stab++;
      end else if (m_pe) begin
        hi_q.push_back(m_ehi);
        last_fall = cyc;
      end
      if (init_done && init_cyc < 0) init_cyc = cyc;
      if (frame_done) fd_cnt++;
      m_pe  = lcd_e;
      m_prs = lcd_rs;
      m_pd  = lcd_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({lcd_e, lcd_rs, lcd_rw, lcd_data} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_bus: got e=%b rs=%b rw=%b data=%h, want all 0",
               lcd_e, lcd_rs, lcd_rw, lcd_data);
    end
    n_vec++;
    if (index !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_index: got %0d want 0", index);
    end
    n_vec++;
    if ({init_done, frame_done} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 00", {init_done, frame_done});
    end
  endtask

  // Expects rst currently high; releases it and checks the whole init sequence
  task automatic test_power_on(input string tag);
    logic [8:0] exp_init[4];
    logic [8:0] got;
    int         k;
    int         hi_ok;
    exp_init = '{9'h038, 9'h00C, 9'h006, 9'h001};
    k = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        wr_q.delete();
        hi_q.delete();
        init_cyc = -1;
      end
      if (lcd_e) begin
        k = i;
        break;
      end
    end
    n_vec++;
    if (k != INIT_WAIT + 1) begin
      n_bad++;
      $display("FAIL %s first_e_rise: got edge %0d want %0d", tag, k, INIT_WAIT + 1);
    end
    for (int i = 0; i < 2000 && !init_done; i++) @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (init_done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s init_done: got %b want 1", tag, init_done);
    end
    for (int j = 0; j < 4; j++) begin
      got = (wr_q.size() > j) ? wr_q[j] : 9'h1FF;
      n_vec++;
      if (got !== exp_init[j]) begin
        n_bad++;
        $display("FAIL %s init_cmd%0d: got rs/data %h want %h", tag, j, got, exp_init[j]);
      end
    end
    hi_ok = 0;
    for (int j = 0; j < 4; j++) if (hi_q.size() > j && hi_q[j] == int'(E_CYCLES)) hi_ok++;
    n_vec++;
    if (hi_ok != 4) begin
      n_bad++;
      $display("FAIL %s e_high_len: got %0d of 4 writes with %0d cycles want 4",
               tag, hi_ok, E_CYCLES);
    end
    n_vec++;
    if (init_cyc - last_fall != int'(CLR_WAIT)) begin
      n_bad++;
      $display("FAIL %s clear_gap: got %0d cycles want %0d",
               tag, init_cyc - last_fall, CLR_WAIT);
    end
  endtask

  task automatic wait_frame_done(input string tag);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frame_done) break;
    end
    if (i == 3000) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s frame_timeout: got no frame_done want pulse", tag);
    end
  endtask

`ifdef LCD_FRAME_SYNC_EN
  task automatic test_frame_sync();
    int r0, f0;
    r0 = rise_cnt;
    repeat (100) @(negedge clk);
    n_vec++;
    if (rise_cnt != r0) begin
      n_bad++;
      $display("FAIL sync_idle: got %0d e rises want 0", rise_cnt - r0);
    end
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    f0 = fd_cnt;
    repeat (1500) @(negedge clk);
    n_vec++;
    if (fd_cnt - f0 != 1 || rise_cnt - r0 != 34) begin
      n_bad++;
      $display("FAIL sync_single: got %0d frames %0d writes want 1 frame 34 writes",
               fd_cnt - f0, rise_cnt - r0);
    end
    frame_req = 1'b1;
    f0 = fd_cnt;
    repeat (1500) @(negedge clk);
    n_vec++;
    if (fd_cnt - f0 < 3) begin
      n_bad++;
      $display("FAIL sync_continuous: got %0d frames want >=3", fd_cnt - f0);
    end
  endtask
`endif

  // One complete frame checked against the addressing rules and the generator text
  task automatic test_frame(input string tag, input bit rnd);
    logic [8:0] exp_q[$];
    logic [8:0] got;
    int         f0;
    wait_frame_done(tag);
    for (int d = 0; d < 6; d++) digit[d] = rnd ? $urandom_range(9, 0) : d + 1;
    wr_q.delete();
    f0 = fd_cnt;
    for (int line = 0; line < 2; line++) begin
      exp_q.push_back({1'b0, (line == 1) ? 8'hC0 : 8'h80});
      for (int p = 0; p < 16; p++) exp_q.push_back({1'b1, gen_char(line * 16 + p)});
    end
    wait_frame_done(tag);
    n_vec++;
    if (fd_cnt - f0 != 1 || index !== 5'd0) begin
      n_bad++;
      $display("FAIL %s frame_pulse: got %0d pulses index %0d want 1 pulse index 0",
               tag, fd_cnt - f0, index);
    end
    n_vec++;
    if (wr_q.size() != 34) begin
      n_bad++;
      $display("FAIL %s frame_len: got %0d writes want 34", tag, wr_q.size());
    end
    for (int j = 0; j < 34; j++) begin
      got = (wr_q.size() > j) ? wr_q[j] : 9'h1FF;
      n_vec++;
      if (got !== exp_q[j]) begin
        n_bad++;
        $display("FAIL %s write%0d: got rs/data %h want %h", tag, j, got, exp_q[j]);
      end
    end
  endtask

  task automatic test_fetch_latency();
    int i;
    logic [8:0] got;
    wait_frame_done("fetch");
    for (int d = 0; d < 6; d++) digit[d] = d + 1;
    wr_q.delete();
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (index == 5'd23) break;
    end
    digit[5] = 9;
    wait_frame_done("fetch");
    got = (wr_q.size() > 25) ? wr_q[25] : 9'h1FF;
    n_vec++;
    if (got !== 9'h139) begin
      n_bad++;
      $display("FAIL fetch_latency: got rs/data %h want 139", got);
    end
  endtask

  task automatic test_reset_mid_write();
    int base, i;
    wait_frame_done("midrst");
    base = data_rise;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (data_rise == base + 10 && lcd_e) break;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if ({lcd_e, lcd_rs, lcd_rw, lcd_data, index, init_done, frame_done} !== 18'd0) begin
      n_bad++;
      $display("FAIL midrst_outputs: got e=%b rs=%b data=%h index=%0d init=%b want all 0",
               lcd_e, lcd_rs, lcd_data, index, init_done);
    end
    test_power_on("rerun");
  endtask

  task automatic test_bus_stability();
    n_vec++;
    if (bad_stab != 0) begin
      n_bad++;
      $display("FAIL bus_stability: got %0d changes while e high want 0", bad_stab);
    end
  endtask

  initial begin
    test_reset();
    test_power_on("power_on");
`ifdef LCD_FRAME_SYNC_EN
    test_frame_sync();
`endif
    test_frame("fixed", 1'b0);
    test_frame("random_a", 1'b1);
    test_frame("random_b", 1'b1);
    test_fetch_latency();
    test_reset_mid_write();
    test_frame("after_reset", 1'b0);
    test_bus_stability();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
